fifo_wr_arbiter: RTL

Write-side arbiter and sequencer for the asynchronous FIFO write port. It shares the single FIFO write interface (`winc`/`wdata`, throttled by `wfull`) among `NUM_REQ` packet sources in the write clock domain. Grants are round-robin and packet-atomic: a source keeps the port until its `last` beat is written. The block sits directly in front of the FIFO write-pointer and full-flag logic.

---
 rtl/fifo_wr_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin, packet-atomic arbiter that shares the async
//                FIFO write port (winc/wdata, throttled by wfull) among
//                NUM_REQ packet sources in the wclk domain. A granted source
//                keeps the port until its last beat is written.
//                Optional mid-packet stall timeout is enabled by defining
//                the macro FIFO_WR_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int STALL_LIMIT = 15
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          stall_abort
);

    localparam int              c_gw        = $clog2(NUM_REQ);
    localparam logic [0:0]      c_st_idle   = 1'b0;
    localparam logic [0:0]      c_st_burst  = 1'b1;
    // Reset the pointer to the last source so that source 0 wins first.
    localparam logic [c_gw-1:0] c_grant_rst = c_gw'(NUM_REQ - 1);

    logic [0:0]            state_q, state_d;
    logic [c_gw-1:0]       grant_id_q, grant_id_d;

    logic [c_gw-1:0]       w_rr_sel;
    logic                  w_any_valid;
    logic                  w_g_valid;
    logic                  w_g_last;
    logic [DATA_WIDTH-1:0] w_g_data;
    logic [NUM_REQ-1:0]    w_g_onehot;
    logic                  w_accept;
    logic                  w_stall_expire;

    assign w_any_valid = |req_valid;

    // Round-robin search: first valid source starting after the last grant.
    always_comb begin
        int unsigned idx;
        logic        found;
        w_rr_sel = grant_id_q;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(grant_id_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                w_rr_sel = c_gw'(idx);
                found    = 1'b1;
            end
        end
    end

    // Select the granted source's handshake and data from the registered grant.
    always_comb begin
        w_g_valid  = 1'b0;
        w_g_last   = 1'b0;
        w_g_data   = '0;
        w_g_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == c_gw'(i)) begin
                w_g_valid     = req_valid[i];
                w_g_last      = req_last[i];
                w_g_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_g_onehot[i] = 1'b1;
            end
        end
    end

    // A beat is written only while holding the port and the FIFO has room.
    assign w_accept = (state_q == c_st_burst) && w_g_valid && !wfull;

`ifdef FIFO_WR_ARB_TIMEOUT_EN
    localparam int c_cnt_w = ($clog2(STALL_LIMIT + 1) > 4) ? $clog2(STALL_LIMIT + 1) : 4;

    logic [c_cnt_w-1:0] stall_cnt_q, stall_cnt_d;
    logic               stall_abort_q, stall_abort_d;

    // Count silent BURST cycles; a full FIFO is not the source's fault, so it clears.
    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        w_stall_expire = 1'b0;
        if ((state_q != c_st_burst) || w_accept || wfull) begin
            stall_cnt_d = '0;
        end else if (!w_g_valid) begin
            if (stall_cnt_q == c_cnt_w'(STALL_LIMIT - 1)) begin
                w_stall_expire = 1'b1;
                stall_cnt_d    = '0;
            end else begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
        stall_abort_d = w_stall_expire;
    end

    // Stall counter and one-cycle abort pulse registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            stall_cnt_q   <= '0;
            stall_abort_q <= 1'b0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            stall_abort_q <= stall_abort_d;
        end
    end

    assign stall_abort = stall_abort_q;
`else
    logic w_unused_stall_limit;

    // Without the timeout a silent source keeps the grant indefinitely.
    assign w_stall_expire       = 1'b0;
    assign stall_abort          = 1'b0;
    assign w_unused_stall_limit = (STALL_LIMIT != 0);
`endif

    // State and grant pointer registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= c_st_idle;
            grant_id_q <= c_grant_rst;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
        end
    end

    // Next state: arbitrate in IDLE, release on the last beat (or a stall abort).
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        case (state_q)
            c_st_idle: begin
                if (w_any_valid) begin
                    grant_id_d = w_rr_sel;
                    state_d    = c_st_burst;
                end
            end
            c_st_burst: begin
                if (w_accept && w_g_last) begin
                    state_d = c_st_idle;
                end else if (w_stall_expire) begin
                    state_d = c_st_idle;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // Outputs: write strobe, data and ready are combinational from the grant.
    always_comb begin
        req_ready = '0;
        winc      = 1'b0;
        wdata     = '0;
        busy      = (state_q == c_st_burst);
        if (w_accept) begin
            req_ready = w_g_onehot;
            winc      = 1'b1;
            wdata     = w_g_data;
        end
    end

    assign grant_id = grant_id_q;

endmodule
`default_nettype wire
